// File: rtl/servo_pkg.sv
// ----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the multi-channel servo shutter controller:
//   - per-channel FSM state encoding (2-bit)
//   - direction constants
//   - default servo position codes
//   - counter-width helper used to size the prescaler/frame/move counters
// ----------------------------------------------------------------------------
package servo_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVE_UP = 2'd1,
        S_MOVE_DN = 2'd2,
        S_SETTLE  = 2'd3
    } state_e;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam logic [7:0] POS_UP_DEF   = 8'hFF;
    localparam logic [7:0] POS_HALT_DEF = 8'h50;
    localparam logic [7:0] POS_DOWN_DEF = 8'h0F;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// ----------------------------------------------------------------------------
// servo_pwm_ch
// One servo PWM output. The pulse width is derived from the requested
// position code and only taken on at the frame start, so every frame carries
// a complete pulse of a single width.
//
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset
//   fcnt_i   in   shared frame counter (0..FRAME_CLKS-1)
//   pos_i    in   requested position code
//   pwm_o    out  registered servo pulse, low while in reset
// ----------------------------------------------------------------------------
module servo_pwm_ch #(
    parameter int         FCW      = 20,
    parameter int         MIN_CLK  = 50000,
    parameter int         STEP_CLK = 196,
    parameter logic [7:0] POS_HALT = 8'h50
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [FCW-1:0] fcnt_i,
    input  logic [7:0]     pos_i,
    output logic           pwm_o
);

    localparam int WW = 32;

    logic [WW-1:0] width_q;
    logic [WW-1:0] width_d;
    logic [WW-1:0] width_new;
    logic [WW-1:0] width_cmp;
    logic          frame_start;
    logic          pwm_q;
    logic          pwm_d;

    assign width_new   = WW'(MIN_CLK) + WW'(pos_i) * WW'(STEP_CLK);
    assign frame_start = (fcnt_i == '0);

    // At the frame start the freshly computed width is already the one that
    // governs this frame, so compare against it rather than the old latch.
    always_comb begin
        width_d   = width_q;
        width_cmp = width_q;
        if (frame_start) begin
            width_d   = width_new;
            width_cmp = width_new;
        end
        pwm_d = (WW'(fcnt_i) < width_cmp);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            width_q <= WW'(MIN_CLK) + WW'(POS_HALT) * WW'(STEP_CLK);
            pwm_q   <= 1'b0;
        end else begin
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_shutter_ctrl.sv
// ----------------------------------------------------------------------------
// servo_shutter_ctrl
// Drives N_CH RC servos. Each edge on a channel's direction input starts a
// timed up or down move; afterwards the servo returns to the halt position.
// A shared 1 ms tick prescaler times the moves and a shared frame counter
// gives every PWM channel the same frame phase.
//
// Ports:
//   clk_50     in   system clock (50 MHz)
//   reset      in   asynchronous active-high reset
//   direct     in   requested direction per channel (1 = up), asynchronous
//   pwm        out  servo pulse per channel
//   busy       out  channel is in a move (registered)
//   pos_up     out  last started move was up (registered)
//   dbg_state  out  per-channel FSM state, 2 bits per channel (channel i at
//                   [2*i+1:2*i])
// ----------------------------------------------------------------------------
module servo_shutter_ctrl
    import servo_pkg::*;
#(
    parameter int         N_CH       = 2,
    parameter int         TICK_CLKS  = 50000,
    parameter int         MOVE_TICKS = 4000,
    parameter int         FRAME_CLKS = 1000000,
    parameter int         MIN_CLK    = 50000,
    parameter int         STEP_CLK   = 196,
    parameter logic [7:0] POS_UP     = POS_UP_DEF,
    parameter logic [7:0] POS_HALT   = POS_HALT_DEF,
    parameter logic [7:0] POS_DOWN   = POS_DOWN_DEF
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic [N_CH-1:0]   direct,
    output logic [N_CH-1:0]   pwm,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   pos_up,
    output logic [2*N_CH-1:0] dbg_state
);

    localparam int TCW = cnt_width(TICK_CLKS);
    localparam int FCW = cnt_width(FRAME_CLKS);
    localparam int MCW = cnt_width(MOVE_TICKS);

    // ---------------- direction synchronisers ----------------
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] dsync_q;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            dsync_q <= '0;
        end else begin
            sync1_q <= direct;
            dsync_q <= sync1_q;
        end
    end

    // ---------------- shared tick prescaler ----------------
    // Free-running; a move never restarts it, which is why a move lasts
    // between MOVE_TICKS-1 and MOVE_TICKS tick periods.
    logic [TCW-1:0] tick_cnt_q;
    logic [TCW-1:0] tick_cnt_d;
    logic           tick;

    assign tick       = (tick_cnt_q == TCW'(TICK_CLKS - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);

    // ---------------- shared frame counter ----------------
    logic [FCW-1:0] fcnt_q;
    logic [FCW-1:0] fcnt_d;

    assign fcnt_d = (fcnt_q == FCW'(FRAME_CLKS - 1)) ? '0 : fcnt_q + FCW'(1);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            fcnt_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // ---------------- per-channel FSM + PWM ----------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_e         state_q;
        state_e         state_d;
        logic           last_dir_q;
        logic           last_dir_d;
        logic [MCW-1:0] move_cnt_q;
        logic [MCW-1:0] move_cnt_d;
        logic           busy_q;
        logic           busy_d;
        logic           pos_up_q;
        logic           pos_up_d;
        logic [7:0]     pos;

        always_comb begin
            state_d    = state_q;
            last_dir_d = last_dir_q;
            move_cnt_d = move_cnt_q;
            pos_up_d   = pos_up_q;
            pos        = POS_HALT;
            case (state_q)
                S_IDLE: begin
                    // Only the difference to the last accepted direction
                    // matters; toggles during a move collapse to nothing.
                    if (dsync_q[g] != last_dir_q) begin
                        last_dir_d = dsync_q[g];
                        move_cnt_d = '0;
                        if (dsync_q[g] == UP) begin
                            state_d  = S_MOVE_UP;
                            pos_up_d = 1'b1;
                        end else begin
                            state_d  = S_MOVE_DN;
                            pos_up_d = 1'b0;
                        end
                    end
                end
                S_MOVE_UP, S_MOVE_DN: begin
                    pos = (state_q == S_MOVE_UP) ? POS_UP : POS_DOWN;
                    if (tick) begin
                        if (move_cnt_q == MCW'(MOVE_TICKS - 1)) begin
                            state_d = S_SETTLE;
                        end else begin
                            move_cnt_d = move_cnt_q + MCW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            busy_d = (state_d == S_MOVE_UP) || (state_d == S_MOVE_DN);
        end

        always_ff @(posedge clk_50 or posedge reset) begin
            if (reset) begin
                state_q    <= S_IDLE;
                last_dir_q <= DOWN;
                move_cnt_q <= '0;
                busy_q     <= 1'b0;
                pos_up_q   <= 1'b0;
            end else begin
                state_q    <= state_d;
                last_dir_q <= last_dir_d;
                move_cnt_q <= move_cnt_d;
                busy_q     <= busy_d;
                pos_up_q   <= pos_up_d;
            end
        end

        servo_pwm_ch #(
            .FCW      (FCW),
            .MIN_CLK  (MIN_CLK),
            .STEP_CLK (STEP_CLK),
            .POS_HALT (POS_HALT)
        ) u_pwm (
            .clk_i  (clk_50),
            .rst_i  (reset),
            .fcnt_i (fcnt_q),
            .pos_i  (pos),
            .pwm_o  (pwm[g])
        );

        assign busy[g]           = busy_q;
        assign pos_up[g]         = pos_up_q;
        assign dbg_state[2*g +: 2] = state_q;
    end

endmodule

// File: tb/tb_servo_shutter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_servo_shutter_ctrl
// Directed, table-driven bench for servo_shutter_ctrl with small timing
// parameters (tick = 10 clocks, move = 5 ticks, frame = 2000 clocks).
// Expected pulse widths: halt 100+80*4=420, up 100+255*4=1120,
// down 100+15*4=160.
// ----------------------------------------------------------------------------
module tb_servo_shutter_ctrl;

    localparam int N_CH   = 2;
    localparam int FRAME  = 2000;
    localparam int HALT_W = 420;
    localparam int UP_W   = 1120;
    localparam int DN_W   = 160;
    localparam int MV_MIN = 41;
    localparam int MV_MAX = 50;

    logic              clk_50;
    logic              reset;
    logic [N_CH-1:0]   direct;
    logic [N_CH-1:0]   pwm;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   pos_up;
    logic [2*N_CH-1:0] dbg_state;

    int total;
    int bad;

    servo_shutter_ctrl #(
        .N_CH       (N_CH),
        .TICK_CLKS  (10),
        .MOVE_TICKS (5),
        .FRAME_CLKS (FRAME),
        .MIN_CLK    (100),
        .STEP_CLK   (4)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .direct    (direct),
        .pwm       (pwm),
        .busy      (busy),
        .pos_up    (pos_up),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk_50 = 1'b0;
        forever #5 clk_50 = ~clk_50;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d need %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Leaves the bench at the negedge just after the frame-start edge R
    // (the edge on which pwm[0] rises).
    task automatic sync_frame(input string name);
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = pwm[0];
        for (int i = 0; i < 2 * FRAME + 100 && !found; i++) begin
            @(negedge clk_50);
            if (!prev && pwm[0]) found = 1'b1;
            prev = pwm[0];
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_sync: got no pwm rise need one within %0d clocks", name, 2 * FRAME + 100);
        end
    endtask

    typedef struct {
        logic [1:0] dir;     // applied so the move spans the next frame start
        logic [1:0] late;    // applied just after that frame start
        logic [1:0] bz2;     // busy three edges after the change
        logic [1:0] pu2;     // pos_up three edges after the change
        logic [1:0] pu_end;  // pos_up at the end of the run
        int         w0;      // pulse width of the frame after the change
        int         w1;
        int         r0;      // number of moves started on each channel
        int         r1;
    } vec_t;

    // Edge offsets below are relative to frame-start edge R.
    // direct changes before edge R+1980 -> FSM moves at R+1982, so the
    // move covers the frame start at R+2000.
    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0] bz1, bz2, pu2, prev_b;
        int w0, w1, w2_0, w2_1, hi0, hi1, r0, r1, e;
        w0 = 0; w1 = 0; w2_0 = 0; w2_1 = 0;
        hi0 = 0; hi1 = 0; r0 = 0; r1 = 0;
        bz1 = 'x; bz2 = 'x; pu2 = 'x;
        sync_frame(tag);
        repeat (1979) @(negedge clk_50);
        direct = v.dir;
        prev_b = busy;
        for (int i = 1; i <= 4020; i++) begin
            @(negedge clk_50);
            e = 1979 + i;
            if (e == 1981) bz1 = busy;
            if (e == 1982) begin
                bz2 = busy;
                pu2 = pos_up;
            end
            if (e == 2000) direct = v.late;
            hi0 += int'(busy[0]);
            hi1 += int'(busy[1]);
            r0  += int'(busy[0] & ~prev_b[0]);
            r1  += int'(busy[1] & ~prev_b[1]);
            prev_b = busy;
            if (e >= 2000 && e < 4000) begin
                w0 += int'(pwm[0]);
                w1 += int'(pwm[1]);
            end
            if (e >= 4000) begin
                w2_0 += int'(pwm[0]);
                w2_1 += int'(pwm[1]);
            end
        end
        chk({tag, "_busy_early"}, int'(bz1), 0);
        chk({tag, "_busy_start"}, int'(bz2), int'(v.bz2));
        chk({tag, "_pos_up_start"}, int'(pu2), int'(v.pu2));
        chk({tag, "_pos_up_end"}, int'(pos_up), int'(v.pu_end));
        chk({tag, "_width0"}, w0, v.w0);
        chk({tag, "_width1"}, w1, v.w1);
        chk({tag, "_next_width0"}, w2_0, HALT_W);
        chk({tag, "_next_width1"}, w2_1, HALT_W);
        chk({tag, "_moves0"}, r0, v.r0);
        chk({tag, "_moves1"}, r1, v.r1);
        chk_range({tag, "_busy_len0"}, hi0, MV_MIN * v.r0, MV_MAX * v.r0);
        chk_range({tag, "_busy_len1"}, hi1, MV_MIN * v.r1, MV_MAX * v.r1);
    endtask

    vec_t vecs[9];

    initial begin
        int w;
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        direct = 2'b00;

        //            dir    late   bz2    pu2    pu_end w0     w1     r0 r1
        vecs[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, HALT_W, HALT_W, 0, 0};
        vecs[1] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, UP_W,   HALT_W, 1, 0};
        vecs[2] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, HALT_W, UP_W,   0, 1};
        vecs[3] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, DN_W,   HALT_W, 1, 0};
        vecs[4] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, HALT_W, DN_W,   0, 1};
        vecs[5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, UP_W,   UP_W,   1, 1};
        vecs[6] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, HALT_W, HALT_W, 0, 0};
        vecs[7] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, DN_W,   DN_W,   1, 1};
        // 0->1->0 inside a move: one up move, then a down move after IDLE
        vecs[8] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, UP_W,   HALT_W, 2, 0};

        // ---------------- reset state ----------------
        repeat (4) @(negedge clk_50);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pos_up", int'(pos_up), 0);
        chk("reset_state", int'(dbg_state), 0);
        reset = 1'b0;

        // ---------------- table ----------------
        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], $sformatf("v%0d", k));
        end

        // ---------------- change in the middle of a pulse ----------------
        // Channel 0 starts an up move while its 420-clock pulse is high; that
        // frame must keep 420, and the move is over before the next frame.
        sync_frame("mid");
        w = 1;
        for (int e = 1; e < FRAME; e++) begin
            if (e == 100) direct = 2'b01;
            @(negedge clk_50);
            if (e == 102) begin
                chk("mid_state", int'(dbg_state[1:0]), 1);
                chk("mid_busy", int'(busy[0]), 1);
            end
            w += int'(pwm[0]);
        end
        chk("mid_cur_width", w, HALT_W);
        w = 0;
        for (int e = FRAME; e < 2 * FRAME; e++) begin
            @(negedge clk_50);
            w += int'(pwm[0]);
        end
        chk("mid_next_width", w, HALT_W);
        chk("mid_pos_up", int'(pos_up), 1);

        // ---------------- reset in the middle of a move ----------------
        // Channel 1 goes up (channel 0 already up, no move); reset lands while
        // the 1120-clock pulse is high.
        sync_frame("rst");
        repeat (1979) @(negedge clk_50);
        direct = 2'b11;
        repeat (31) @(negedge clk_50);
        chk("rst_pre_busy", int'(busy), 2);
        chk("rst_pre_pwm1", int'(pwm[1]), 1);
        reset = 1'b1;
        #1;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pos_up", int'(pos_up), 0);
        chk("rst_state", int'(dbg_state), 0);
        direct = 2'b00;
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
